// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin owner selection for the shared 4-digit hex display
// Each owner keeps the display for at least HOLD_CYCLES while other requesters wait.
module display_arbiter #(
  parameter int          HOLD_CYCLES  = 100000000,
  parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [63:0] value,
  input  logic [7:0]  dp_pos,
  input  logic [3:0]  dp_req,
  output logic [3:0]  gnt,
  output logic [15:0] digits,
  output logic [1:0]  ones_place,
  output logic        dp_en,
  output logic        busy
);

  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;
  logic [1:0]    last_owner, owner_nxt;
  logic [3:0]    gnt_nxt;
  logic [15:0]   digits_nxt;
  logic [1:0]    ones_nxt;
  logic          dp_en_nxt, busy_nxt;
  logic [3:0]    others;
  logic [1:0]    pick;
  logic          load;

  // Searches last+1 .. last+4, so the previous owner is considered last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign others = req & ~(4'b0001 << last_owner);
  assign pick   = rr_pick(req, last_owner);

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    owner_nxt  = last_owner;
    gnt_nxt    = gnt;
    digits_nxt = digits;
    ones_nxt   = ones_place;
    dp_en_nxt  = dp_en;
    busy_nxt   = busy;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          hold_nxt  = HOLD_RELOAD;
          load      = 1'b1;
        end
      end
      GRANT: begin
        if (!req[last_owner]) begin
          if (|others) begin
            owner_nxt = pick;
            hold_nxt  = HOLD_RELOAD;
            load      = 1'b1;
          end else begin
            state_nxt  = IDLE;
            gnt_nxt    = 4'b0000;
            busy_nxt   = 1'b0;
            digits_nxt = IDLE_PATTERN;
            ones_nxt   = 2'd0;
            dp_en_nxt  = 1'b0;
          end
        end else if (hold_cnt == '0 && |others) begin
          owner_nxt = pick;
          hold_nxt  = HOLD_RELOAD;
          load      = 1'b1;
        end else begin
          if (hold_cnt != '0) hold_nxt = hold_cnt - CW'(1);
          load = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // The owner's inputs are reloaded on every granted edge so live changes are tracked.
    if (load) begin
      gnt_nxt    = 4'b0001 << owner_nxt;
      busy_nxt   = 1'b1;
      digits_nxt = value[16*owner_nxt +: 16];
      ones_nxt   = dp_pos[2*owner_nxt +: 2];
      dp_en_nxt  = dp_req[owner_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_owner <= 2'd3;
      gnt        <= 4'b0000;
      digits     <= IDLE_PATTERN;
      ones_place <= 2'd0;
      dp_en      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      last_owner <= owner_nxt;
      gnt        <= gnt_nxt;
      digits     <= digits_nxt;
      ones_place <= ones_nxt;
      dp_en      <= dp_en_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - directed-vector bench for display_arbiter with HOLD_CYCLES=4
module tb_display_arbiter;

  logic        clk_100mhz;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] value;
  logic [7:0]  dp_pos;
  logic [3:0]  dp_req;
  logic [3:0]  gnt;
  logic [15:0] digits;
  logic [1:0]  ones_place;
  logic        dp_en;
  logic        busy;

  int total = 0;
  int bad   = 0;

  display_arbiter #(.HOLD_CYCLES(4), .IDLE_PATTERN(16'h0000)) dut (
    .clk        (clk_100mhz),
    .rst_n      (rst_n),
    .req        (req),
    .value      (value),
    .dp_pos     (dp_pos),
    .dp_req     (dp_req),
    .gnt        (gnt),
    .digits     (digits),
    .ones_place (ones_place),
    .dp_en      (dp_en),
    .busy       (busy)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".gnt"},    64'(gnt),        64'h0);
    check_eq({tag, ".busy"},   64'(busy),       64'h0);
    check_eq({tag, ".digits"}, 64'(digits),     64'h0);
    check_eq({tag, ".ones"},   64'(ones_place), 64'h0);
    check_eq({tag, ".dp_en"},  64'(dp_en),      64'h0);
  endtask

  logic [3:0]  exp_gnt;
  logic [15:0] exp_dig;

  initial begin
    rst_n  = 1'b0;
    req    = 4'b0000;
    value  = 64'h0;
    dp_pos = 8'h0;
    dp_req = 4'b0000;
    #12;
    check_idle("reset");
    rst_n = 1'b1;

    // single request
    req    = 4'b0100;
    value  = {16'h0000, 16'hBEEF, 32'h0};
    dp_pos = 8'b00_10_00_00;
    dp_req = 4'b0100;
    tick();
    check_eq("single.gnt",    64'(gnt),        64'h4);
    check_eq("single.digits", 64'(digits),     64'hBEEF);
    check_eq("single.ones",   64'(ones_place), 64'h2);
    check_eq("single.dp_en",  64'(dp_en),      64'h1);
    check_eq("single.busy",   64'(busy),       64'h1);
    for (int i = 0; i < 10; i++) tick();
    check_eq("single.held", 64'(gnt), 64'h4);

    // release to idle
    req = 4'b0000;
    tick();
    check_idle("release");

    // contention rotation from reset
    reset_pulse();
    value  = {16'hA333, 16'hA222, 16'hA111, 16'hA000};
    dp_req = 4'b0000;
    req    = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      tick();
      case (((c - 1) / 4) % 4)
        0: begin exp_gnt = 4'b0001; exp_dig = 16'hA000; end
        1: begin exp_gnt = 4'b0010; exp_dig = 16'hA111; end
        2: begin exp_gnt = 4'b0100; exp_dig = 16'hA222; end
        default: begin exp_gnt = 4'b1000; exp_dig = 16'hA333; end
      endcase
      check_eq($sformatf("rot%0d.gnt", c),    64'(gnt),    64'(exp_gnt));
      check_eq($sformatf("rot%0d.digits", c), 64'(digits), 64'(exp_dig));
    end

    // early release hands over without an idle cycle
    req = 4'b0000;
    tick();
    reset_pulse();
    req = 4'b1001;
    tick();
    check_eq("early.first", 64'(gnt), 64'h1);
    tick();
    req = 4'b1000;
    tick();
    check_eq("early.switch", 64'(gnt), 64'h8);
    check_eq("early.busy",   64'(busy), 64'h1);
    check_eq("early.digits", 64'(digits), 64'hA333);
    req = 4'b1001;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq($sformatf("early.hold%0d", k), 64'(gnt), 64'h8);
    end
    tick();
    check_eq("early.rotate", 64'(gnt), 64'h1);

    // live tracking of the owner's value
    req = 4'b0000;
    tick();
    reset_pulse();
    value = {16'h0, 16'h0, 16'h1234, 16'h0};
    req   = 4'b0010;
    tick();
    check_eq("live.gnt0",    64'(gnt),    64'h2);
    check_eq("live.digits0", 64'(digits), 64'h1234);
    tick();
    value = {16'h0, 16'h0, 16'h5678, 16'h0};
    check_eq("live.lag",     64'(digits), 64'h1234);
    tick();
    check_eq("live.digits1", 64'(digits), 64'h5678);
    check_eq("live.gnt1",    64'(gnt),    64'h2);

    // asynchronous reset mid-grant
    value = {16'hD333, 16'hD222, 16'hD111, 16'hD000};
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("areset.gnt",    64'(gnt),    64'h0);
    check_eq("areset.digits", 64'(digits), 64'h0);
    check_eq("areset.busy",   64'(busy),   64'h0);
    req   = 4'b1010;
    #1;
    rst_n = 1'b1;
    tick();
    check_eq("areset.first",  64'(gnt),    64'h2);
    check_eq("areset.dig",    64'(digits), 64'hD111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
